// File: rtl/hazard_forwarding_unit.sv
// -----------------------------------------------------------------------------
// hazard_forwarding_unit
//
// Hazard detection and operand forwarding for the five-stage ARM pipeline.
// Lives in ID. Keeps a private three-entry destination scoreboard (EX, MEM,
// WB) that mirrors what the pipeline registers hold. From it, this block
// drives the PA/PB/PD operand-mux selects, the control-unit NOP select and the
// PC / IF-ID load enables. It also counts the load-use stall cycles it inserts.
//
// Ports
//   Clk            : clock, all state updates on the rising edge
//   Clr            : synchronous active-high reset
//   ID_Rn/Rm/Rd    : source register fields of the ID instruction
//   ID_use_Rn/Rm/Rd: the ID instruction really reads that operand
//   ID_dest        : destination register after the RD mux (R14 for BL)
//   ID_RF_enable   : the ID instruction writes the register file
//   ID_load_instr  : the ID instruction is a load
//   FWD_PA/PB/PD   : 00 reg file, 01 EX result, 10 MEM result, 11 WB data
//   NOP_sel        : 1 injects a bubble into ID/EX
//   LE_PC, LE_IFID : load enables, deasserted to hold fetch/decode
//   stall_count    : saturating count of stall cycles inserted
// -----------------------------------------------------------------------------
module hazard_forwarding_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic [3:0]       ID_dest,
  input  logic             ID_RF_enable,
  input  logic             ID_load_instr,
  output logic [1:0]       FWD_PA,
  output logic [1:0]       FWD_PB,
  output logic [1:0]       FWD_PD,
  output logic             NOP_sel,
  output logic             LE_PC,
  output logic             LE_IFID,
  output logic [CNT_W-1:0] stall_count
);

  // Pipeline view: RUN normally, STALL for the single cycle after a load-use
  // bubble has been inserted.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [3:0] PC_REG = 4'd15;

  // Scoreboard entries
  logic [3:0]       ex_rd_q,  ex_rd_d;
  logic             ex_we_q,  ex_we_d;
  logic             ex_ld_q,  ex_ld_d;
  logic [3:0]       mem_rd_q, mem_rd_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       wb_rd_q,  wb_rd_d;
  logic             wb_we_q,  wb_we_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  state_t           state_q,  state_d;

  // Operands packed as slot 0 = Rn (PA), slot 1 = Rm (PB), slot 2 = Rd (PD)
  logic [11:0] src_flat;
  logic [2:0]  use_flat;
  logic [5:0]  fwd_flat;
  logic [2:0]  ld_hit;
  logic        hazard;

  assign src_flat = {ID_Rd, ID_Rm, ID_Rn};
  assign use_flat = {ID_use_Rd, ID_use_Rm, ID_use_Rn};

  // ---------------------------------------------------------------------------
  // Per-operand match and select. R15 is never forwarded because the PC path
  // already supplies its value.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_operand
      logic [3:0] src_r;
      logic       src_ok;
      logic       hit_ex;
      logic       hit_mem;
      logic       hit_wb;
      logic [1:0] sel;

      assign src_r   = src_flat[gi*4 +: 4];
      assign src_ok  = use_flat[gi] && (src_r != PC_REG);
      assign hit_ex  = src_ok && ex_we_q  && (ex_rd_q  == src_r);
      assign hit_mem = src_ok && mem_we_q && (mem_rd_q == src_r);
      assign hit_wb  = src_ok && wb_we_q  && (wb_rd_q  == src_r);

      // A load in EX has no data yet, so an EX hit on a load falls through to
      // the older stages; the stall below holds the instruction until the
      // load reaches MEM.
      always_comb begin
        sel = 2'b00;
        if (hit_ex && !ex_ld_q) begin
          sel = 2'b01;
        end else if (hit_mem) begin
          sel = 2'b10;
        end else if (hit_wb) begin
          sel = 2'b11;
        end
      end

      assign fwd_flat[gi*2 +: 2] = sel;
      assign ld_hit[gi]          = hit_ex && ex_ld_q;
    end
  endgenerate

  // In STALL the EX entry is the bubble we just inserted, so a second hazard
  // on the held instruction is impossible; gating by state makes that explicit.
  assign hazard = (|ld_hit) && (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Scoreboard shifts every cycle; the load flag does not follow into MEM.
    wb_rd_d  = mem_rd_q;
    wb_we_d  = mem_we_q;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    ex_rd_d  = ID_dest;
    ex_we_d  = ID_RF_enable;
    ex_ld_d  = ID_load_instr;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (hazard) begin
      // Bubble enters EX instead of the held instruction.
      ex_rd_d = 4'd0;
      ex_we_d = 1'b0;
      ex_ld_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_RUN:   state_d = hazard ? ST_STALL : ST_RUN;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      ex_rd_q  <= 4'd0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= 4'd0;
      mem_we_q <= 1'b0;
      wb_rd_q  <= 4'd0;
      wb_we_q  <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_RUN;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      wb_rd_q  <= wb_rd_d;
      wb_we_q  <= wb_we_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign FWD_PA      = fwd_flat[1:0];
  assign FWD_PB      = fwd_flat[3:2];
  assign FWD_PD      = fwd_flat[5:4];
  assign NOP_sel     = hazard;
  assign LE_PC       = !hazard;
  assign LE_IFID     = !hazard;
  assign stall_count = cnt_q;

endmodule
